id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised successor decode stage for the 16-bit pipelined core.
- Holds one fetched instruction in an internal IF/ID register and decodes it into control and immediate fields.
- Detects load-use, branch-flag and branch-register hazards, resolves B/BR branches in decode and issues a redirect to fetch.
- Uses a valid/ready handshake on both sides, sitting between fetch and execute.

Parameters:
- PC_W, 16, width of PC, pc_plus2, immediates, next_pc and reg_rs.
- RF_AW, 4, register-address width; register 0 is hard-wired zero.
- HALT_STICKY, 1, 1: after HLT issues, the stage accepts nothing until reset; 0: HLT is a one-shot pulse only.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- instruction  in  16  fetched instruction.
- pc_plus2  in  PC_W  PC+2 of the fetched instruction.
- flags  in  3  architectural NZV.
- reg_rs  in  PC_W  register-file read of rs, used by BR.
- ex_valid  in  1  execute holds a valid instruction.
- ex_rd  in  RF_AW  execute destination register.
- ex_mem_read  in  1  execute instruction is LW.
- ex_reg_write  in  1  execute instruction writes rd.
- ex_sets_flags  in  1  execute instruction updates NZV.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- rd, rs, rt  out  RF_AW each  register addresses.
- imm  out  PC_W  extended immediate.
- alu_op  out  4  ALU operation.
- alu_src1, alu_src2  out  1 each  ALU operand selects.
- mem_read_en, mem_write_en  out  1 each  memory controls.
- reg_write_en, reg_write_src  out  1 each  writeback controls.
- sets_flags  out  1  decoded instruction updates flags.
- next_pc  out  PC_W  redirect target.
- redirect  out  1  taken-branch pulse to fetch.
- halt  out  1  HLT issued.
- d_pc_plus2  out  PC_W  passthrough of the held PC+2.

Behaviour:
- Reset (asynchronous):
  - id_valid=0, halted=0.
  - All outputs 0: out_valid, redirect, halt, in_ready, and all control enables.
  - First cycle after reset release: in_ready=1.
- Capture: id register loads {instruction, pc_plus2} when in_valid && in_ready.
  - in_ready = !halted && (!id_valid || out_fire) && !redirect.
  - out_fire = out_valid && out_ready.
  - If out_fire and a new capture coincide, the new instruction replaces the held one with no bubble.
- Decode is combinational from the held instruction. Opcode map:
  - ADD/SUB/XOR/RED/PADDSB → alu_op 0/1/2/8/9, register-register.
  - SLL/SRA/ROR → alu_op 4/5/6, imm = sign-extended [3:0].
  - LW/SW → alu_op 10, imm = sext([3:0])<<1; SW sets rt=[11:8].
  - LLB/LHB → alu_op 11/12, rs=[11:8], imm = zext([7:0]).
  - B → imm = sext([8:0])<<1.
  - BR → target = reg_rs.
  - PCS → alu_op 13, alu_src1=1.
  - HLT.
  - sets_flags = 1 for ADD, SUB, XOR, SLL, SRA, ROR; 0 otherwise.
  - Unused fields drive 0, never X.
- Hazard (combinational). stall = id_valid && any of:
  - load-use: ex_valid && ex_mem_read && ex_rd≠0 && ex_rd matches a used source register.
  - flag: B or BR && ex_valid && ex_sets_flags.
  - BR register: BR && ex_valid && ex_reg_write && ex_rd==rs && rs≠0.
- Output: out_valid = id_valid && !stall && !halted. Bundle fields are held stable while out_valid && !out_ready.
- Branch conditions, on cond=[11:9]:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 && N=0
  - 011 LT: N=1
  - 100 GE: Z=1 || (Z=0 && N=0)
  - 101 LE: N=1 || Z=1
  - 110 OV: V=1
  - 111 always
- Branch resolution:
  - redirect = out_fire && branch && taken, a one-cycle pulse.
  - next_pc = BR ? reg_rs : held pc_plus2 + imm, modulo 2^PC_W; otherwise next_pc = held pc_plus2.
  - A fetch instruction offered in the redirect cycle is not captured.
- Halt:
  - halt pulses on out_fire of HLT.
  - With HALT_STICKY=1: halted sets, in_ready=0 and out_valid=0 until reset.
- Reset mid-operation discards the held instruction; no redirect or halt is emitted.

Optional Feature:
- Macro ID_PERF_CNT_EN. When defined, adds three outputs, each 16-bit saturating and cleared by rst:
  - perf_stall_cycles: counts cycles with id_valid && stall.
  - perf_branches: counts out_fire of B/BR.
  - perf_taken: counts redirect.
- When undefined, these ports and counters do not exist, and the rest of the behaviour is identical.

Decomposition:
- Package id_pkg holds:
  - opcode constants OP_ADD..OP_HLT;
  - ALU op constants ALU_ADD=0 .. ALU_PASS=13;
  - branch-condition constants;
  - flag bit indices N=2, Z=1, V=0.
- Sub-module id_branch_eval, combinational (cond, flags → taken), shared with later branch predictors.
- Next-PC adder reuses cla_16bit.

Test Plan:
- Hold: ADD R1,R2,R3 (0x0123) with out_ready=0 for 3 cycles → out_valid=1, fields stable, in_ready=0; ready then rises → single fire, alu_op=0.
- Load-use: EX holds LW R4 (ex_mem_read=1, ex_rd=4); decode SUB R5,R4,R6 → out_valid=0 while the EX condition persists; clearing ex_valid → issue next cycle.
- Taken branch: B EQ +4 with Z=1, pc_plus2=0x0010 → redirect=1 for one cycle, next_pc=0x0018, the concurrently offered fetch word is not captured.
- Flag stall: B NE while ex_sets_flags=1 → stall; next cycle Z=0 → redirect, next_pc correct.
- BR register stall: BR with rs=R7 while EX writes R7 → stall; after clearing, reg_rs=0x1234 → next_pc=0x1234.
- HLT (HALT_STICKY=1): halt pulses once, then in_ready stays 0 for 10 cycles; rst asserted mid-hold → all outputs 0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/id_pkg.sv
// ----------------------------------------------------------------------------
// id_pkg
// Shared definitions for the decode stage of the 16-bit pipelined core:
// opcode encodings, ALU operation codes, branch-condition codes and the bit
// positions of the N/Z/V flags inside the 3-bit flags vector.
// No ports (package).
// ----------------------------------------------------------------------------
package id_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_e;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_XOR    = 4'd2;
    localparam logic [3:0] ALU_SLL    = 4'd4;
    localparam logic [3:0] ALU_SRA    = 4'd5;
    localparam logic [3:0] ALU_ROR    = 4'd6;
    localparam logic [3:0] ALU_RED    = 4'd8;
    localparam logic [3:0] ALU_PADDSB = 4'd9;
    localparam logic [3:0] ALU_ADDR   = 4'd10;
    localparam logic [3:0] ALU_LLB    = 4'd11;
    localparam logic [3:0] ALU_LHB    = 4'd12;
    localparam logic [3:0] ALU_PASS   = 4'd13;

    typedef enum logic [2:0] {
        COND_NE = 3'b000,
        COND_EQ = 3'b001,
        COND_GT = 3'b010,
        COND_LT = 3'b011,
        COND_GE = 3'b100,
        COND_LE = 3'b101,
        COND_OV = 3'b110,
        COND_AL = 3'b111
    } cond_e;

    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cla_16bit.sv
// ----------------------------------------------------------------------------
// cla_16bit
// 16-bit carry-lookahead adder: four 4-bit groups with group generate and
// propagate, group carries resolved by lookahead, ripple inside each group.
// Ports: a, b (addends), cin (carry in), sum (a+b+cin mod 2^16), cout.
// ----------------------------------------------------------------------------
module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [4:0]  gc;
    logic [3:0]  gg;
    logic [3:0]  gp;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        gg = '0;
        gp = '0;
        gc = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        gc[0] = cin;
        for (int unsigned k = 0; k < 4; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int unsigned k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int unsigned j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        sum  = p ^ c;
        cout = gc[4];
    end

endmodule

// File: rtl/id_branch_eval.sv
// ----------------------------------------------------------------------------
// id_branch_eval
// Combinational branch-condition evaluator, shared with branch predictors.
// Ports: cond (3-bit condition code), flags (N,Z,V at id_pkg FLAG_* bits),
//        taken (condition satisfied).
// ----------------------------------------------------------------------------
module id_branch_eval
    import id_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic n;
    logic z;
    logic v;

    always_comb begin
        n     = flags[FLAG_N];
        z     = flags[FLAG_Z];
        v     = flags[FLAG_V];
        taken = 1'b0;
        case (cond_e'(cond))
            COND_NE: taken = ~z;
            COND_EQ: taken = z;
            COND_GT: taken = ~z & ~n;
            COND_LT: taken = n;
            COND_GE: taken = z | ~n;     // Z | (!Z & !N) reduces to Z | !N
            COND_LE: taken = n | z;
            COND_OV: taken = v;
            COND_AL: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// ----------------------------------------------------------------------------
// id_stage_pipe
// Decode stage: holds one instruction in an IF/ID register, decodes it,
// detects load-use / branch-flag / branch-register hazards, resolves B/BR
// and redirects fetch. Valid/ready handshake toward fetch and execute.
// Optional macro ID_PERF_CNT_EN adds 16-bit saturating perf counters.
// Ports:
//   clk, rst (async, active high)
//   in_valid/in_ready, instruction, pc_plus2     : fetch side
//   flags, reg_rs                                : architectural NZV, rs read
//   ex_valid, ex_rd, ex_mem_read, ex_reg_write,
//   ex_sets_flags                                : execute-stage hazard info
//   out_valid/out_ready, rd, rs, rt, imm, alu_op, alu_src1, alu_src2,
//   mem_read_en, mem_write_en, reg_write_en, reg_write_src, sets_flags,
//   d_pc_plus2                                   : decoded bundle
//   next_pc, redirect, halt                      : control to fetch
//   perf_stall_cycles, perf_branches, perf_taken : only with ID_PERF_CNT_EN
// ----------------------------------------------------------------------------
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int unsigned PC_W        = 16,
    parameter int unsigned RF_AW       = 4,
    parameter bit          HALT_STICKY = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      instruction,
    input  logic [PC_W-1:0]  pc_plus2,
    input  logic [2:0]       flags,
    input  logic [PC_W-1:0]  reg_rs,
    input  logic             ex_valid,
    input  logic [RF_AW-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic             ex_sets_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RF_AW-1:0] rd,
    output logic [RF_AW-1:0] rs,
    output logic [RF_AW-1:0] rt,
    output logic [PC_W-1:0]  imm,
    output logic [3:0]       alu_op,
    output logic             alu_src1,
    output logic             alu_src2,
    output logic             mem_read_en,
    output logic             mem_write_en,
    output logic             reg_write_en,
    output logic             reg_write_src,
    output logic             sets_flags,
    output logic [PC_W-1:0]  next_pc,
    output logic             redirect,
    output logic             halt,
    output logic [PC_W-1:0]  d_pc_plus2
`ifdef ID_PERF_CNT_EN
    ,
    output logic [15:0]      perf_stall_cycles,
    output logic [15:0]      perf_branches,
    output logic [15:0]      perf_taken
`endif
);

    logic [15:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            id_valid_q, id_valid_d;
    logic            halted_q, halted_d;

    opcode_e         op;
    logic            is_branch, is_br, is_hlt, uses_rs, uses_rt;
    logic            load_use, flag_haz, br_haz, stall;
    logic            out_fire, capture, taken;
    logic [PC_W-1:0] branch_sum;

    assign op = opcode_e'(instr_q[15:12]);

    // Decode fields are forced to zero while the register is empty so nothing
    // downstream sees a phantom ADD R0 from the reset value.
    always_comb begin : decode
        rd = '0; rs = '0; rt = '0; imm = '0;
        alu_op = ALU_ADD; alu_src1 = 1'b0; alu_src2 = 1'b0;
        mem_read_en = 1'b0; mem_write_en = 1'b0;
        reg_write_en = 1'b0; reg_write_src = 1'b0; sets_flags = 1'b0;
        is_branch = 1'b0; is_br = 1'b0; is_hlt = 1'b0;
        uses_rs = 1'b0; uses_rt = 1'b0;
        if (id_valid_q) begin
            case (op)
                OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
                    rd = RF_AW'(instr_q[11:8]);
                    rs = RF_AW'(instr_q[7:4]);
                    rt = RF_AW'(instr_q[3:0]);
                    uses_rs = 1'b1; uses_rt = 1'b1; reg_write_en = 1'b1;
                    case (op)
                        OP_SUB:    alu_op = ALU_SUB;
                        OP_XOR:    alu_op = ALU_XOR;
                        OP_RED:    alu_op = ALU_RED;
                        OP_PADDSB: alu_op = ALU_PADDSB;
                        default:   alu_op = ALU_ADD;
                    endcase
                    sets_flags = (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
                end
                OP_SLL, OP_SRA, OP_ROR: begin
                    rd = RF_AW'(instr_q[11:8]);
                    rs = RF_AW'(instr_q[7:4]);
                    imm = {{(PC_W-4){instr_q[3]}}, instr_q[3:0]};
                    uses_rs = 1'b1; alu_src2 = 1'b1; reg_write_en = 1'b1; sets_flags = 1'b1;
                    alu_op = (op == OP_SLL) ? ALU_SLL : (op == OP_SRA) ? ALU_SRA : ALU_ROR;
                end
                OP_LW, OP_SW: begin
                    rs = RF_AW'(instr_q[7:4]);
                    imm = {{(PC_W-5){instr_q[3]}}, instr_q[3:0], 1'b0};
                    uses_rs = 1'b1; alu_src2 = 1'b1; alu_op = ALU_ADDR;
                    if (op == OP_LW) begin
                        rd = RF_AW'(instr_q[11:8]);
                        mem_read_en = 1'b1; reg_write_en = 1'b1; reg_write_src = 1'b1;
                    end else begin
                        rt = RF_AW'(instr_q[11:8]);
                        uses_rt = 1'b1; mem_write_en = 1'b1;
                    end
                end
                OP_LLB, OP_LHB: begin
                    rd = RF_AW'(instr_q[11:8]);
                    rs = RF_AW'(instr_q[11:8]);
                    imm = {{(PC_W-8){1'b0}}, instr_q[7:0]};
                    uses_rs = 1'b1; alu_src2 = 1'b1; reg_write_en = 1'b1;
                    alu_op = (op == OP_LLB) ? ALU_LLB : ALU_LHB;
                end
                OP_B: begin
                    imm = {{(PC_W-10){instr_q[8]}}, instr_q[8:0], 1'b0};
                    is_branch = 1'b1;
                end
                OP_BR: begin
                    rs = RF_AW'(instr_q[7:4]);
                    uses_rs = 1'b1; is_branch = 1'b1; is_br = 1'b1;
                end
                OP_PCS: begin
                    rd = RF_AW'(instr_q[11:8]);
                    alu_op = ALU_PASS; alu_src1 = 1'b1; reg_write_en = 1'b1;
                end
                OP_HLT: is_hlt = 1'b1;
            endcase
        end
    end

    id_branch_eval u_branch_eval (
        .cond  (instr_q[11:9]),
        .flags (flags),
        .taken (taken)
    );

    generate
        if (PC_W == 16) begin : g_cla
            logic adder_cout_unused;
            cla_16bit u_cla (
                .a    (pc_q),
                .b    (imm),
                .cin  (1'b0),
                .sum  (branch_sum),
                .cout (adder_cout_unused)
            );
        end else begin : g_add
            assign branch_sum = pc_q + imm;
        end
    endgenerate

    always_comb begin : control
        load_use  = ex_valid && ex_mem_read && (ex_rd != '0) &&
                    ((uses_rs && (ex_rd == rs)) || (uses_rt && (ex_rd == rt)));
        flag_haz  = is_branch && ex_valid && ex_sets_flags;
        br_haz    = is_br && ex_valid && ex_reg_write && (ex_rd == rs) && (rs != '0);
        stall     = id_valid_q && (load_use || flag_haz || br_haz);
        out_valid = id_valid_q && !stall && !halted_q;
        out_fire  = out_valid && out_ready;
        redirect  = out_fire && is_branch && taken;
        halt      = out_fire && is_hlt;
        next_pc   = pc_q;
        if (is_branch && taken) begin
            next_pc = is_br ? reg_rs : branch_sum;
        end
        d_pc_plus2 = pc_q;
        // rst gates in_ready so it reads 0 for the whole reset window.
        in_ready  = !rst && !halted_q && (!id_valid_q || out_fire) && !redirect;
        capture   = in_valid && in_ready;
        instr_d    = capture ? instruction : instr_q;
        pc_d       = capture ? pc_plus2 : pc_q;
        id_valid_d = capture || (id_valid_q && !out_fire);
        halted_d   = halted_q || (HALT_STICKY && halt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= '0;
            pc_q       <= '0;
            id_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            halted_q   <= halted_d;
        end
    end

`ifdef ID_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] br_cnt_q, br_cnt_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (stall && (stall_cnt_q != '1))                  stall_cnt_d = stall_cnt_q + 16'd1;
        if (out_fire && is_branch && (br_cnt_q != '1))     br_cnt_d    = br_cnt_q + 16'd1;
        if (redirect && (taken_cnt_q != '1))               taken_cnt_d = taken_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_branches     = br_cnt_q;
    assign perf_taken        = taken_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// ----------------------------------------------------------------------------
// tb_id_stage_pipe
// Scoreboard bench for id_stage_pipe: the driver pushes a reference decode of
// every accepted instruction; a negedge monitor compares handshake, hazard
// stalls, bundle fields, redirect and halt against that queue.
// ----------------------------------------------------------------------------
module tb_id_stage_pipe;

    typedef struct packed {
        logic [3:0]  rd, rs, rt;
        logic [15:0] imm;
        logic [3:0]  alu;
        logic        src1, src2, mr, mw, rwe, rws, sf;
        logic        is_b, is_br, is_hlt, use_rs, use_rt;
        logic [15:0] ins, pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] instruction, pc_plus2, reg_rs, imm, next_pc, d_pc_plus2;
    logic [2:0]  flags;
    logic        ex_valid, ex_mem_read, ex_reg_write, ex_sets_flags;
    logic [3:0]  ex_rd, rd, rs, rt, alu_op;
    logic        alu_src1, alu_src2, mem_read_en, mem_write_en;
    logic        reg_write_en, reg_write_src, sets_flags, redirect, halt;
`ifdef ID_PERF_CNT_EN
    logic [15:0] perf_stall_cycles, perf_branches, perf_taken;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   halt_seen = 0;
    int   redirects_m = 0;
    bit   halted_m = 1'b0;
    bit   rand_env = 1'b0;

    always #5 clk = ~clk;

    id_stage_pipe #(.PC_W(16), .RF_AW(4), .HALT_STICKY(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_plus2(pc_plus2), .flags(flags), .reg_rs(reg_rs),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .ex_sets_flags(ex_sets_flags),
        .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .rs(rs), .rt(rt),
        .imm(imm), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .reg_write_en(reg_write_en), .reg_write_src(reg_write_src),
        .sets_flags(sets_flags), .next_pc(next_pc), .redirect(redirect),
        .halt(halt), .d_pc_plus2(d_pc_plus2)
`ifdef ID_PERF_CNT_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_branches(perf_branches),
        .perf_taken(perf_taken)
`endif
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event at %0t", name, $time);
    endtask

    // Reference decode written from the instruction-format table.
    function automatic exp_t model(input logic [15:0] ins, input logic [15:0] pc);
        exp_t e;
        int   op;
        int   s;
        e = '0;
        e.ins = ins;
        e.pc  = pc;
        op = int'(ins[15:12]);
        case (op)
            0, 1, 2, 3, 7: begin
                e.rd = ins[11:8]; e.rs = ins[7:4]; e.rt = ins[3:0];
                e.use_rs = 1'b1; e.use_rt = 1'b1; e.rwe = 1'b1;
                e.alu = (op == 3) ? 4'd8 : (op == 7) ? 4'd9 : 4'(op);
                e.sf  = (op <= 2);
            end
            4, 5, 6: begin
                s = int'(ins[3:0]); if (s > 7) s -= 16;
                e.rd = ins[11:8]; e.rs = ins[7:4]; e.imm = 16'(s);
                e.use_rs = 1'b1; e.src2 = 1'b1; e.rwe = 1'b1; e.sf = 1'b1; e.alu = 4'(op);
            end
            8, 9: begin
                s = int'(ins[3:0]); if (s > 7) s -= 16;
                e.rs = ins[7:4]; e.imm = 16'(2 * s); e.use_rs = 1'b1; e.src2 = 1'b1; e.alu = 4'd10;
                if (op == 8) begin
                    e.rd = ins[11:8]; e.mr = 1'b1; e.rwe = 1'b1; e.rws = 1'b1;
                end else begin
                    e.rt = ins[11:8]; e.mw = 1'b1; e.use_rt = 1'b1;
                end
            end
            10, 11: begin
                e.rd = ins[11:8]; e.rs = ins[11:8]; e.imm = {8'h00, ins[7:0]};
                e.use_rs = 1'b1; e.src2 = 1'b1; e.rwe = 1'b1; e.alu = 4'(op + 1);
            end
            12: begin
                s = int'(ins[8:0]); if (s > 255) s -= 512;
                e.imm = 16'(2 * s); e.is_b = 1'b1;
            end
            13: begin
                e.rs = ins[7:4]; e.use_rs = 1'b1; e.is_b = 1'b1; e.is_br = 1'b1;
            end
            14: begin
                e.rd = ins[11:8]; e.alu = 4'd13; e.src1 = 1'b1; e.rwe = 1'b1;
            end
            default: e.is_hlt = 1'b1;
        endcase
        return e;
    endfunction

    function automatic bit taken_model(input logic [2:0] c, input logic [2:0] f);
        bit n, z, v;
        n = f[2]; z = f[1]; v = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Monitor: front of the queue is the instruction the stage should hold.
    exp_t        m_e;
    bit          m_have, m_hz, m_ov, m_fire, m_taken, m_redir;
    logic [15:0] m_npc;
    always @(negedge clk) begin
        if (!rst) begin
            m_have = (exp_q.size() != 0);
            m_e    = m_have ? exp_q[0] : '0;
            m_hz   = m_have && ex_valid && (
                       (ex_mem_read && ex_rd != 4'd0 &&
                        ((m_e.use_rs && ex_rd == m_e.rs) || (m_e.use_rt && ex_rd == m_e.rt))) ||
                       (m_e.is_b && ex_sets_flags) ||
                       (m_e.is_br && ex_reg_write && ex_rd == m_e.rs && m_e.rs != 4'd0));
            m_ov    = m_have && !m_hz && !halted_m;
            m_fire  = m_ov && out_ready;
            m_taken = m_e.is_b && taken_model(m_e.ins[11:9], flags);
            m_redir = m_fire && m_taken;
            check("out_valid", 80'(out_valid), 80'(m_ov));
            check("in_ready", 80'(in_ready), 80'(!halted_m && (!m_have || m_fire) && !m_redir));
            check("redirect", 80'(redirect), 80'(m_redir));
            check("halt", 80'(halt), 80'(m_fire && m_e.is_hlt));
            if (m_ov) begin
                m_npc = m_taken ? (m_e.is_br ? reg_rs : 16'(m_e.pc + m_e.imm)) : m_e.pc;
                check("bundle",
                      80'({rd, rs, rt, imm, alu_op, alu_src1, alu_src2, mem_read_en, mem_write_en,
                           reg_write_en, reg_write_src, sets_flags, next_pc, d_pc_plus2}),
                      80'({m_e.rd, m_e.rs, m_e.rt, m_e.imm, m_e.alu, m_e.src1, m_e.src2, m_e.mr,
                           m_e.mw, m_e.rwe, m_e.rws, m_e.sf, m_npc, m_e.pc}));
            end
            if (halt) halt_seen++;
            if (m_fire) begin
                void'(exp_q.pop_front());
                if (m_e.is_hlt) halted_m = 1'b1;
                if (m_redir) redirects_m++;
            end
        end
    end

    // Random execute-side and downstream environment.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_env) begin
                out_ready     = ($urandom_range(0, 3) != 0);
                ex_valid      = ($urandom_range(0, 2) == 0);
                ex_rd         = 4'($urandom_range(0, 7));
                ex_mem_read   = 1'($urandom_range(0, 1));
                ex_reg_write  = 1'($urandom_range(0, 1));
                ex_sets_flags = ($urandom_range(0, 3) == 0);
                flags         = 3'($urandom);
                reg_rs        = 16'($urandom);
            end
        end
    end

    task automatic offer(input logic [15:0] ins, input logic [15:0] pc);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1; instruction = ins; pc_plus2 = pc;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            n++;
        end
        if (acc) exp_q.push_back(model(ins, pc));
        else bound_fail("offer_accept");
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) bound_fail("drain");
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [15:0] ri;
        int          n;
        rst = 1'b1; in_valid = 1'b0; instruction = '0; pc_plus2 = '0;
        flags = '0; reg_rs = '0; out_ready = 1'b1;
        ex_valid = 1'b0; ex_rd = '0; ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_sets_flags = 1'b0;
        cycles(3);
        check("rst_in_ready", 80'(in_ready), 80'(0));
        check("rst_out_valid", 80'(out_valid), 80'(0));
        check("rst_redirect_halt", 80'({redirect, halt}), 80'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 80'(in_ready), 80'(1));
        cycles(1);

        // Hold with out_ready low, then fire with a back-to-back capture.
        out_ready = 1'b0;
        offer(16'h0123, 16'h0100);
        cycles(3);
        out_ready = 1'b1;
        offer(16'h2456, 16'h0102);
        wait_empty();

        // Load-use stall on R4.
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 4'd4; ex_reg_write = 1'b1;
        offer(16'h1546, 16'h0200);
        cycles(3);
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        wait_empty();

        // Taken B EQ +4 with a fetch word offered during the redirect.
        flags = 3'b010;
        offer(16'hC204, 16'h0010);
        offer(16'h0777, 16'h0012);
        wait_empty();

        // Flag stall on B NE, then Z clears.
        ex_valid = 1'b1; ex_sets_flags = 1'b1; ex_rd = 4'd1;
        offer(16'hC002, 16'h0020);
        cycles(2);
        ex_valid = 1'b0; ex_sets_flags = 1'b0; flags = 3'b000;
        wait_empty();

        // BR R7 register stall.
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd7;
        offer(16'hDE70, 16'h0030);
        cycles(2);
        ex_valid = 1'b0; reg_rs = 16'h1234;
        wait_empty();

        // Randomized traffic, HLT excluded.
        rand_env = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) cycles(1);
            ri = 16'($urandom);
            ri[7] = 1'b0;
            if (ri[15:12] == 4'hF) ri[15:12] = 4'h0;
            offer(ri, 16'($urandom) & 16'hFFFE);
        end
        wait_empty();
        rand_env = 1'b0;
        @(posedge clk);
        #2;
        ex_valid = 1'b0; out_ready = 1'b1;
        cycles(1);

`ifdef ID_PERF_CNT_EN
        check("perf_taken", 80'(perf_taken), 80'(redirects_m));
`endif

        // HLT: single pulse, then nothing accepted until reset.
        offer(16'hF000, 16'h0040);
        n = 0;
        while (halt_seen == 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (halt_seen == 0) bound_fail("halt_wait");
        #1;
        in_valid = 1'b1; instruction = 16'h0123; pc_plus2 = 16'h0042;
        cycles(10);
        check("halt_once", 80'(halt_seen), 80'(1));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_ctrl", 80'({out_valid, in_ready, redirect, halt, reg_write_en, mem_read_en}), 80'(0));
        check("mid_rst_fields", 80'({rd, alu_op, imm, next_pc, d_pc_plus2}), 80'(0));
        exp_q.delete();
        halted_m = 1'b0;
        in_valid = 1'b0;
        cycles(2);
        rst = 1'b0;
        offer(16'h0123, 16'h0050);
        wait_empty();
        check("halt_after_rst", 80'(halt_seen), 80'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
